dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Data-memory responder on the processor's dmem port. It serves loads and stores issued
//   by the pipeline over address_dmem/data/wren and returns q_dmem with 1-cycle latency,
//   matching the synchronous-RAM timing the MEM stage expects. Optionally decodes an MMIO
//   window: cycle counter, scratch register and a TX FIFO drained over a valid/ready port.
// PARAMETERS
//   ADDR_WIDTH  12       word-address width of address_dmem
//   DATA_WIDTH  32       data word width
//   MEM_DEPTH   4096     RAM words (2**ADDR_WIDTH)
//   TX_DEPTH    4        TX FIFO entries (power of 2, >=2)
//   MMIO_BASE   12'hFF0  first word of the 16-word MMIO window
// PORTS
//   clock         in   1           system clock, rising edge
//   reset         in   1           asynchronous, active-high reset
//   address_dmem  in   ADDR_WIDTH  word address from the MEM stage
//   data          in   DATA_WIDTH  store data
//   wren          in   1           store strobe; sampled at the rising edge
//   q_dmem        out  DATA_WIDTH  load data, valid 1 cycle after the address
//   tx_valid      out  1           TX FIFO head is valid
//   tx_data       out  DATA_WIDTH  TX FIFO head word
//   tx_ready      in   1           sink accepts the head word this cycle
// BEHAVIOUR
//   - Reset (async, high): q_dmem=0, tx_valid=0, tx_data=0, cycle=0, scratch=0,
//     FIFO count=0, overflow=0. RAM contents are not cleared.
//   - Read: q_dmem <= word[address_dmem] at every edge, regardless of wren (latency 1).
//   - Write: wren=1 writes data to word[address_dmem] at the edge.
//   - Read-during-write to the same address returns the OLD word; the new word appears
//     on the next read.
//   - MMIO window, only with DMEM_MMIO_EN; offsets are relative to MMIO_BASE:
//       +0 CYCLE   read-only; +1 every clock; wraps FFFF_FFFF->0; writes ignored.
//       +1 SCRATCH read/write.
//       +2 TXDATA  write pushes data into the FIFO; reads return 0.
//       +3 STATUS  read {overflow[31], 27'b0, count[3:0]}; write with data[31]=1
//                  clears overflow.
//       +4..+15    read 0; writes ignored.
//   - RAM words shadowed by the window are never read or written.
//   - MMIO read data is registered exactly like RAM, so latency stays 1.
//     CYCLE returns the pre-increment value at the edge.
//   - FIFO handshake:
//       pop when tx_valid & tx_ready; tx_valid = (count!=0); tx_data = head, or 0 if empty.
//       Push when full without a same-cycle pop: word dropped, overflow set (sticky).
//       Push and pop in the same cycle when full: both happen; count is unchanged.
//       Pointers wrap modulo TX_DEPTH.
//       Overflow set and clear in the same cycle: set wins.
//   - Reset mid-transfer empties the FIFO immediately; a word in flight is lost.
// CONFIGURATION
//   DMEM_MMIO_EN defined:   MMIO window, counter, scratch and FIFO are present.
//   DMEM_MMIO_EN undefined: every address maps to RAM; tx_valid=0 and tx_data=0
//     constantly; tx_ready is ignored.
// STRUCTURE
//   - Package dmem_pkg: MMIO offset constants (OFF_CYCLE, OFF_SCRATCH, OFF_TXDATA,
//     OFF_STATUS), STATUS_OVF_BIT=31, STATUS_CNT_LSB=0.
//   - Sub-module dmem_tx_fifo: sync FIFO with push/pop/full/empty/count; the overflow
//     flag lives in the parent.
//   - RAM is inferred in the top level as a synchronous read/write array.
// TESTING
//   1. Write 32'hDEADBEEF to addr 5, then read addr 5 -> q_dmem=DEADBEEF one cycle later.
//   2. Same-edge wren=1 to addr 7 (old 1, new 2) -> q_dmem=1; next read of addr 7 -> 2.
//   3. Assert reset mid-run -> q_dmem=0, tx_valid=0 immediately; after release, CYCLE
//      reads count from 0 (consecutive reads differ by 1).
//   4. MMIO_EN, tx_ready=0: push 5 words 1..5 -> STATUS=8000_0004; sink pops 1,2,3,4 in
//      order; word 5 dropped.
//   5. FIFO full with tx_ready=1 and a push of 9 in the same cycle -> count stays 4;
//      9 emerges after 3 more pops.
//   6. MMIO_EN undefined: write 0xAA to FF1, read FF1 -> 0xAA (RAM); tx_valid stays 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants for the dmem responder: MMIO register offsets and STATUS field layout.
package dmem_pkg;

    localparam int MMIO_WINDOW_BITS = 4;

    localparam logic [MMIO_WINDOW_BITS-1:0] OFF_CYCLE   = 4'd0;
    localparam logic [MMIO_WINDOW_BITS-1:0] OFF_SCRATCH = 4'd1;
    localparam logic [MMIO_WINDOW_BITS-1:0] OFF_TXDATA  = 4'd2;
    localparam logic [MMIO_WINDOW_BITS-1:0] OFF_STATUS  = 4'd3;

    localparam int STATUS_OVF_BIT = 31;
    localparam int STATUS_CNT_LSB = 0;

endpackage

// File: rtl/dmem_tx_fifo.sv
// Synchronous TX FIFO; a push into a full FIFO is accepted only when a pop happens in the
// same cycle. The head reads as zero while empty.
module dmem_tx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : store[rd_ptr];

    // NOTE: storage has no reset; only pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: synchronous RAM with 1-cycle read latency. Defining DMEM_MMIO_EN
// adds an MMIO window with cycle counter, scratch register and a TX FIFO.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 4096,
    parameter int                    TX_DEPTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = 12'hFF0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address_dmem,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wren,
    output logic [DATA_WIDTH-1:0] q_dmem,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_ready
);
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic                  in_window;
    logic [DATA_WIDTH-1:0] mmio_rdata;

`ifdef DMEM_MMIO_EN
    localparam int CNT_W = $clog2(TX_DEPTH) + 1;

    logic [MMIO_WINDOW_BITS-1:0] offset;
    logic [DATA_WIDTH-1:0]       cycle;
    logic [DATA_WIDTH-1:0]       scratch;
    logic                        overflow;
    logic                        mmio_write;
    logic                        push;
    logic                        pop;
    logic                        full;
    logic                        empty;
    logic                        ovf_set;
    logic                        ovf_clr;
    logic [CNT_W-1:0]            count;

    assign offset     = address_dmem[MMIO_WINDOW_BITS-1:0];
    assign in_window  = (address_dmem[ADDR_WIDTH-1:MMIO_WINDOW_BITS] ==
                         MMIO_BASE[ADDR_WIDTH-1:MMIO_WINDOW_BITS]);
    assign mmio_write = wren & in_window;
    assign push       = mmio_write & (offset == OFF_TXDATA);
    assign pop        = tx_valid & tx_ready;
    assign ovf_set    = push & full & ~pop;
    assign ovf_clr    = mmio_write & (offset == OFF_STATUS) & data[STATUS_OVF_BIT];
    assign tx_valid   = ~empty;

    dmem_tx_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (data),
        .head      (tx_data),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle    <= '0;
            scratch  <= '0;
            overflow <= 1'b0;
        end else begin
            cycle <= cycle + DATA_WIDTH'(1);
            if (mmio_write && offset == OFF_SCRATCH) scratch <= data;
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    // NOTE: default first so every path assigns mmio_rdata and no latch is inferred.
    always_comb begin
        mmio_rdata = '0;
        case (offset)
            OFF_CYCLE:   mmio_rdata = cycle;
            OFF_SCRATCH: mmio_rdata = scratch;
            OFF_STATUS: begin
                mmio_rdata[STATUS_OVF_BIT]            = overflow;
                mmio_rdata[STATUS_CNT_LSB +: CNT_W]   = count;
            end
            default:     mmio_rdata = '0;
        endcase
    end
`else
    logic unused_tx_ready;

    assign unused_tx_ready = tx_ready;
    assign in_window       = 1'b0;
    assign mmio_rdata      = '0;
    assign tx_valid        = 1'b0;
    assign tx_data         = '0;
`endif

    // NOTE: the RAM array is deliberately not reset; contents survive reset.
    always_ff @(posedge clock) begin
        if (wren && !in_window) mem[address_dmem] <= data;
    end

    // Read samples the pre-write word, so read-during-write returns the old data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) q_dmem <= '0;
        else       q_dmem <= in_window ? mmio_rdata : mem[address_dmem];
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder; MMIO scenarios run when DMEM_MMIO_EN is defined.
module tb_dmem_responder;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam logic [AW-1:0] BASE = 12'hFF0;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] address_dmem = '0;
    logic [DW-1:0] data = '0;
    logic          wren = 1'b0;
    logic          tx_ready = 1'b0;
    logic [DW-1:0] q_dmem;
    logic          tx_valid;
    logic [DW-1:0] tx_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] model_mem [int];
    logic [DW-1:0] sb_q [$];
    logic [DW-1:0] tx_q [$];
    logic [DW-1:0] model_scratch = '0;
    logic          model_ovf = 1'b0;

    logic [AW-1:0] ram_addrs [8] = '{12'h000, 12'h001, 12'h002, 12'h064,
                                     12'h0C8, 12'h3E8, 12'hFA0, 12'hFEF};
    logic [DW-1:0] ram_datas [8] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 32'h5A5A_5A5A,
                                     32'h0000_0001, 32'h8000_0000, 32'h1234_5678, 32'hCAFE_F00D};

    dmem_responder dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        logic [DW-1:0] st;
`ifdef DMEM_MMIO_EN
        if (a[AW-1:4] == BASE[AW-1:4]) begin
            st = '0;
            case (a[3:0])
                4'd1: st = model_scratch;
                4'd3: st = {model_ovf, 27'b0, 4'(tx_q.size())};
                default: st = '0;
            endcase
            return st;
        end
`endif
        st = model_mem.exists(int'(a)) ? model_mem[int'(a)] : '0;
        return st;
    endfunction

    function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
`ifdef DMEM_MMIO_EN
        if (a[AW-1:4] == BASE[AW-1:4]) begin
            case (a[3:0])
                4'd1: model_scratch = d;
                4'd2: if (tx_q.size() < 4) tx_q.push_back(d); else model_ovf = 1'b1;
                4'd3: if (d[31]) model_ovf = 1'b0;
                default: ;
            endcase
            return;
        end
`endif
        model_mem[int'(a)] = d;
    endfunction

    // One bus cycle; the expected read word is queued before the edge, compared after it.
    task automatic access(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we);
        address_dmem = a;
        data         = d;
        wren         = we;
        sb_q.push_back(model_read(a));
        if (we) model_write(a, d);
        @(posedge clock);
        #1;
        wren = 1'b0;
    endtask

    task automatic test_reset;
        #1 reset = 1'b1;
        #2;
        n_cmp++; if (q_dmem !== '0)  begin n_err++; $display("FAIL reset_q: q_dmem=%h expected 0", q_dmem); end
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        n_cmp++; if (tx_data !== '0) begin n_err++; $display("FAIL reset_tx_data: got %h expected 0", tx_data); end
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic test_ram;
        logic [DW-1:0] exp;
        access(12'd5, 32'hDEAD_BEEF, 1'b1);
        void'(sb_q.pop_front());
        access(12'd5, '0, 1'b0);
        exp = sb_q.pop_front();
        n_cmp++; if (q_dmem !== exp) begin n_err++; $display("FAIL ram_addr5: q_dmem=%h expected %h", q_dmem, exp); end
        for (int i = 0; i < 8; i++) begin
            access(ram_addrs[i], ram_datas[i], 1'b1);
            void'(sb_q.pop_front());
        end
        for (int i = 7; i >= 0; i--) begin
            access(ram_addrs[i], '0, 1'b0);
            exp = sb_q.pop_front();
            n_cmp++;
            if (q_dmem !== exp) begin
                n_err++; $display("FAIL ram_table[%0d]: q_dmem=%h expected %h", i, q_dmem, exp);
            end
        end
    endtask

    task automatic test_rdw;
        logic [DW-1:0] exp;
        access(12'd7, 32'd1, 1'b1);
        void'(sb_q.pop_front());
        access(12'd7, 32'd2, 1'b1);
        exp = sb_q.pop_front();
        n_cmp++; if (q_dmem !== exp) begin n_err++; $display("FAIL rdw_old: q_dmem=%h expected %h", q_dmem, exp); end
        access(12'd7, '0, 1'b0);
        exp = sb_q.pop_front();
        n_cmp++; if (q_dmem !== exp) begin n_err++; $display("FAIL rdw_new: q_dmem=%h expected %h", q_dmem, exp); end
    endtask

    task automatic test_reset_mid;
        logic [DW-1:0] exp;
        access(12'd5, '0, 1'b0);
        exp = sb_q.pop_front();
        n_cmp++; if (q_dmem !== exp) begin n_err++; $display("FAIL pre_reset_read: q_dmem=%h expected %h", q_dmem, exp); end
`ifdef DMEM_MMIO_EN
        access(BASE + 12'd2, 32'h77, 1'b1);
        void'(sb_q.pop_front());
`endif
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (q_dmem !== '0) begin n_err++; $display("FAIL midreset_q: q_dmem=%h expected 0", q_dmem); end
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL midreset_tx_valid: got %b expected 0", tx_valid); end
        n_cmp++; if (tx_data !== '0) begin n_err++; $display("FAIL midreset_tx_data: got %h expected 0", tx_data); end
        tx_q.delete();
        sb_q.delete();
        model_scratch = '0;
        model_ovf     = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
`ifdef DMEM_MMIO_EN
        for (int i = 0; i < 3; i++) begin
            access(BASE, '0, 1'b0);
            void'(sb_q.pop_front());
            n_cmp++;
            if (q_dmem !== DW'(i)) begin
                n_err++; $display("FAIL cycle_after_reset[%0d]: q_dmem=%h expected %h", i, q_dmem, DW'(i));
            end
        end
`else
        access(12'd5, '0, 1'b0);
        exp = sb_q.pop_front();
        n_cmp++; if (q_dmem !== exp) begin n_err++; $display("FAIL ram_kept_over_reset: q_dmem=%h expected %h", q_dmem, exp); end
`endif
    endtask

`ifdef DMEM_MMIO_EN
    // Pops every word the model still holds, checking order and validity, then checks empty.
    task automatic test_drain(input string name);
        logic [DW-1:0] exp;
        tx_ready = 1'b1;
        while (tx_q.size() > 0) begin
            exp = tx_q.pop_front();
            n_cmp++;
            if (tx_valid !== 1'b1 || tx_data !== exp) begin
                n_err++;
                $display("FAIL %s_pop: tx_valid=%b tx_data=%h expected valid=1 data=%h", name, tx_valid, tx_data, exp);
            end
            @(posedge clock);
            #1;
        end
        tx_ready = 1'b0;
        n_cmp++;
        if (tx_valid !== 1'b0 || tx_data !== '0) begin
            n_err++; $display("FAIL %s_empty: tx_valid=%b tx_data=%h expected 0/0", name, tx_valid, tx_data);
        end
    endtask

    task automatic test_overflow;
        logic [DW-1:0] exp;
        tx_ready = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            access(BASE + 12'd2, DW'(v), 1'b1);
            void'(sb_q.pop_front());
        end
        access(BASE + 12'd3, '0, 1'b0);
        exp = sb_q.pop_front();
        n_cmp++; if (q_dmem !== exp) begin n_err++; $display("FAIL status_full_ovf: q_dmem=%h expected %h", q_dmem, exp); end
        test_drain("overflow");
        access(BASE + 12'd3, '0, 1'b0);
        exp = sb_q.pop_front();
        n_cmp++; if (q_dmem !== exp) begin n_err++; $display("FAIL status_sticky: q_dmem=%h expected %h", q_dmem, exp); end
        access(BASE + 12'd3, 32'h8000_0000, 1'b1);
        void'(sb_q.pop_front());
        access(BASE + 12'd3, '0, 1'b0);
        exp = sb_q.pop_front();
        n_cmp++; if (q_dmem !== exp) begin n_err++; $display("FAIL status_cleared: q_dmem=%h expected %h", q_dmem, exp); end
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] exp;
        tx_ready = 1'b0;
        for (int v = 10; v <= 13; v++) begin
            access(BASE + 12'd2, DW'(v), 1'b1);
            void'(sb_q.pop_front());
        end
        address_dmem = BASE + 12'd2;
        data         = 32'd9;
        wren         = 1'b1;
        tx_ready     = 1'b1;
        exp = tx_q.pop_front();
        tx_q.push_back(32'd9);
        n_cmp++;
        if (tx_valid !== 1'b1 || tx_data !== exp) begin
            n_err++; $display("FAIL full_pushpop_head: tx_valid=%b tx_data=%h expected 1/%h", tx_valid, tx_data, exp);
        end
        @(posedge clock);
        #1;
        wren     = 1'b0;
        tx_ready = 1'b0;
        access(BASE + 12'd3, '0, 1'b0);
        exp = sb_q.pop_front();
        n_cmp++; if (q_dmem !== exp) begin n_err++; $display("FAIL full_pushpop_status: q_dmem=%h expected %h", q_dmem, exp); end
        test_drain("pushpop");
    endtask

    task automatic test_scratch;
        logic [DW-1:0] exp;
        logic [DW-1:0] c0;
        access(BASE + 12'd1, 32'h1234_5678, 1'b1);
        void'(sb_q.pop_front());
        access(BASE + 12'd1, '0, 1'b0);
        exp = sb_q.pop_front();
        n_cmp++; if (q_dmem !== exp) begin n_err++; $display("FAIL scratch_rw: q_dmem=%h expected %h", q_dmem, exp); end
        access(BASE, 32'hFFFF_0000, 1'b1);
        void'(sb_q.pop_front());
        access(BASE, '0, 1'b0);
        void'(sb_q.pop_front());
        c0 = q_dmem;
        access(BASE, '0, 1'b0);
        void'(sb_q.pop_front());
        n_cmp++; if (q_dmem !== c0 + 32'd1) begin n_err++; $display("FAIL cycle_step: q_dmem=%h expected %h", q_dmem, c0 + 32'd1); end
        access(BASE + 12'd6, '0, 1'b0);
        exp = sb_q.pop_front();
        n_cmp++; if (q_dmem !== exp) begin n_err++; $display("FAIL unused_offset: q_dmem=%h expected %h", q_dmem, exp); end
        access(BASE + 12'd2, '0, 1'b0);
        exp = sb_q.pop_front();
        n_cmp++; if (q_dmem !== exp) begin n_err++; $display("FAIL txdata_read: q_dmem=%h expected %h", q_dmem, exp); end
    endtask
`else
    task automatic test_no_mmio;
        logic [DW-1:0] exp;
        access(BASE + 12'd1, 32'hAA, 1'b1);
        void'(sb_q.pop_front());
        access(BASE + 12'd1, '0, 1'b0);
        exp = sb_q.pop_front();
        n_cmp++; if (q_dmem !== exp) begin n_err++; $display("FAIL ram_at_ff1: q_dmem=%h expected %h", q_dmem, exp); end
        tx_ready = 1'b1;
        access(BASE + 12'd2, 32'h55, 1'b1);
        void'(sb_q.pop_front());
        n_cmp++;
        if (tx_valid !== 1'b0 || tx_data !== '0) begin
            n_err++; $display("FAIL tx_idle: tx_valid=%b tx_data=%h expected 0/0", tx_valid, tx_data);
        end
        access(BASE + 12'd2, '0, 1'b0);
        exp = sb_q.pop_front();
        n_cmp++; if (q_dmem !== exp) begin n_err++; $display("FAIL ram_at_ff2: q_dmem=%h expected %h", q_dmem, exp); end
        tx_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_ram();
        test_rdw();
        test_reset_mid();
`ifdef DMEM_MMIO_EN
        test_overflow();
        test_back_to_back();
        test_scratch();
`else
        test_no_mmio();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
